// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - host-to-device PS/2 command byte transmitter
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int START_TIMEOUT  = 750000,
    parameter int BIT_TIMEOUT    = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       PS2_clk_in,
    input  logic       PS2_dat_in,
    output logic       PS2_clk_oe,
    output logic       PS2_dat_oe
);
    localparam int TO_MAX = (START_TIMEOUT > BIT_TIMEOUT) ? START_TIMEOUT : BIT_TIMEOUT;
    localparam int TW     = $clog2(TO_MAX + 1);
    localparam int IW     = $clog2(INHIBIT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE} state_t;
    state_t state, state_n;

    logic [1:0]    clk_sync, dat_sync;
    logic          clk_prev;
    logic          sync_clk, sync_dat, fall, guarded;
    logic [7:0]    shreg, shreg_n;
    logic          par, par_n;
    logic [3:0]    bitcnt, bitcnt_n;
    logic [IW-1:0] inh_cnt, inh_cnt_n;
    logic [TW-1:0] to_cnt, to_cnt_n;
    logic          clk_oe_n, dat_oe_n;

    assign sync_clk = clk_sync[1];
    assign sync_dat = dat_sync[1];
    assign fall     = clk_prev & ~sync_clk;
    assign guarded  = (state == REQ) || (state == SEND) || (state == ACK) || (state == WAIT_IDLE);
    assign tx_ready = (state == IDLE);
    assign tx_busy  = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            clk_sync   <= 2'b11;
            dat_sync   <= 2'b11;
            clk_prev   <= 1'b1;
            shreg      <= '0;
            par        <= 1'b0;
            bitcnt     <= '0;
            inh_cnt    <= '0;
            to_cnt     <= '0;
            PS2_clk_oe <= 1'b0;
            PS2_dat_oe <= 1'b0;
        end else begin
            state      <= state_n;
            clk_sync   <= {clk_sync[0], PS2_clk_in};
            dat_sync   <= {dat_sync[0], PS2_dat_in};
            clk_prev   <= sync_clk;
            shreg      <= shreg_n;
            par        <= par_n;
            bitcnt     <= bitcnt_n;
            inh_cnt    <= inh_cnt_n;
            to_cnt     <= to_cnt_n;
            PS2_clk_oe <= clk_oe_n;
            PS2_dat_oe <= dat_oe_n;
        end
    end

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        par_n     = par;
        bitcnt_n  = bitcnt;
        inh_cnt_n = inh_cnt;
        to_cnt_n  = guarded ? to_cnt - TW'(1) : to_cnt;
        clk_oe_n  = PS2_clk_oe;
        dat_oe_n  = PS2_dat_oe;
        tx_done   = 1'b0;
        tx_error  = 1'b0;
        case (state)
            IDLE: begin
                clk_oe_n = 1'b0;
                dat_oe_n = 1'b0;
                if (tx_valid) begin
                    shreg_n   = tx_data;
                    par_n     = ~^tx_data;
                    inh_cnt_n = IW'(INHIBIT_CYCLES - 1);
                    clk_oe_n  = 1'b1;
                    state_n   = INHIBIT;
                end
            end
            INHIBIT: begin
                // Start-timeout is loaded on entry so the REQ cycle itself counts.
                if (inh_cnt == '0) begin
                    clk_oe_n = 1'b0;
                    dat_oe_n = 1'b1;
                    to_cnt_n = TW'(START_TIMEOUT);
                    state_n  = REQ;
                end else begin
                    inh_cnt_n = inh_cnt - IW'(1);
                end
            end
            REQ: begin
                bitcnt_n = '0;
                state_n  = SEND;
            end
            SEND: begin
                if (fall) begin
                    to_cnt_n = TW'(BIT_TIMEOUT);
                    bitcnt_n = bitcnt + 4'd1;
                    if (bitcnt < 4'd8) begin
                        dat_oe_n = ~shreg[bitcnt[2:0]];
                    end else if (bitcnt == 4'd8) begin
                        dat_oe_n = ~par;
                    end else begin
                        dat_oe_n = 1'b0;
                        state_n  = ACK;
                    end
                end
            end
            ACK: begin
                if (fall) begin
                    to_cnt_n = TW'(BIT_TIMEOUT);
                    if (sync_dat) begin
                        tx_error = 1'b1;
                        state_n  = IDLE;
                    end else begin
                        state_n = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (sync_clk && sync_dat) begin
                    tx_done = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // An expired timer wins over any other outcome in the same cycle.
        if (guarded && to_cnt == '0) begin
            to_cnt_n = '0;
            clk_oe_n = 1'b0;
            dat_oe_n = 1'b0;
            tx_done  = 1'b0;
            tx_error = 1'b1;
            state_n  = IDLE;
        end
    end
endmodule
